wm16_seq_ctrl: RTL and testbench

//  Sequencer for 16x16 unsigned multiplies on one shared WM8bit 8x8 Wallace

---
 rtl/wm16_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_wm16_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm16_seq_ctrl.sv
//==============================================================================
// Module   : wm16_seq_ctrl (with helper wm8bit)
// Brief    : 16x16 unsigned multiply sequenced over one shared 8x8 Wallace
//            multiplier, four partial products accumulated into 32 bits.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wm8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] w_pp [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp
      assign w_pp[gi] = {8'b0, a & {8{b[gi]}}} << gi;
    end
  endgenerate

  // 3:2 compressor carry vector; bits beyond 15 are dropped because the
  // true product always fits in 16 bits.
  function automatic logic [15:0] f_maj(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] w_s1_s0, w_s1_c0, w_s1_s1, w_s1_c1;
  logic [15:0] w_s2_s0, w_s2_c0, w_s2_s1, w_s2_c1;
  logic [15:0] w_s3_s, w_s3_c;
  logic [15:0] w_s4_s, w_s4_c;

  // Layer 1: 8 rows -> 6
  assign w_s1_s0 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
  assign w_s1_c0 = f_maj(w_pp[0], w_pp[1], w_pp[2]);
  assign w_s1_s1 = w_pp[3] ^ w_pp[4] ^ w_pp[5];
  assign w_s1_c1 = f_maj(w_pp[3], w_pp[4], w_pp[5]);

  // Layer 2: 6 rows -> 4
  assign w_s2_s0 = w_s1_s0 ^ w_s1_c0 ^ w_s1_s1;
  assign w_s2_c0 = f_maj(w_s1_s0, w_s1_c0, w_s1_s1);
  assign w_s2_s1 = w_s1_c1 ^ w_pp[6] ^ w_pp[7];
  assign w_s2_c1 = f_maj(w_s1_c1, w_pp[6], w_pp[7]);

  // Layer 3: 4 rows -> 3
  assign w_s3_s = w_s2_s0 ^ w_s2_c0 ^ w_s2_s1;
  assign w_s3_c = f_maj(w_s2_s0, w_s2_c0, w_s2_s1);

  // Layer 4: 3 rows -> 2, then carry-propagate
  assign w_s4_s = w_s3_s ^ w_s3_c ^ w_s2_c1;
  assign w_s4_c = f_maj(w_s3_s, w_s3_c, w_s2_c1);

  assign p = w_s4_s + w_s4_c;

endmodule

module wm16_seq_ctrl #(
  parameter int unsigned ZERO_SKIP = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_step;
  logic [31:0]      r_acc;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [TAG_W-1:0] r_tag;

  logic [7:0]  w_mul_a;
  logic [7:0]  w_mul_b;
  logic [15:0] w_prod;
  logic [31:0] w_term;
  logic        w_skip;

  // step[1] picks the high byte of a, step[0] the high byte of b
  assign w_mul_a = r_step[1] ? r_a[15:8] : r_a[7:0];
  assign w_mul_b = r_step[0] ? r_b[15:8] : r_b[7:0];

  wm8bit u_wm8bit (
    .a (w_mul_a),
    .b (w_mul_b),
    .p (w_prod)
  );

  always_comb begin
    w_term = 32'd0;
    case (r_step)
      2'd0:    w_term = {16'd0, w_prod};
      2'd1,
      2'd2:    w_term = {8'd0, w_prod, 8'd0};
      default: w_term = {w_prod, 16'd0};
    endcase
  end

  assign w_skip = (ZERO_SKIP != 0) && ((in_a == 16'd0) || (in_b == 16'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= 2'd0;
      r_acc   <= 32'd0;
      r_a     <= 16'd0;
      r_b     <= 16'd0;
      r_tag   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_tag   <= in_tag;
            r_acc   <= 32'd0;
            r_step  <= 2'd0;
            r_state <= w_skip ? ST_DONE : ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc  <= r_acc + w_term;
          // wraps back to 0 on the final step, leaving it ready for reuse
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_res   = r_acc;
  assign out_tag   = r_tag;

endmodule

`default_nettype wire

// File: tb/tb_wm16_seq_ctrl.sv
//==============================================================================
// Module   : tb_wm16_seq_ctrl
// Brief    : Directed-vector and random back-to-back bench for wm16_seq_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wm16_seq_ctrl;

  localparam int NVEC  = 12;
  localparam int NRAND = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] out_res;

  logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
  logic [15:0] z_in_a, z_in_b;
  logic [3:0]  z_in_tag, z_out_tag;
  logic [31:0] z_out_res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wm16_seq_ctrl #(.ZERO_SKIP(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .busy(busy)
  );

  wm16_seq_ctrl #(.ZERO_SKIP(0), .TAG_W(4)) dut_noskip (
    .clk(clk), .rst_n(rst_n),
    .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_a(z_in_a), .in_b(z_in_b), .in_tag(z_in_tag),
    .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_res(z_out_res), .out_tag(z_out_tag), .busy(z_busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Latency is counted in clock edges after the accept edge until out_valid
  // is seen: four MUL edges normally, none when the zero skip goes straight
  // to DONE on the accept edge.
  task automatic run_txn(input int idx, input vec_t v);
    int lat;
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({s, "_in_ready"}, in_ready, 1);
    in_a = v.a; in_b = v.b; in_tag = v.tag; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF; in_tag = ~v.tag;
    chk({s, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({s, "_latency"}, lat, v.lat);
    chk({s, "_res"}, out_res, v.res);
    chk({s, "_tag"}, out_tag, v.tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({s, "_release"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 16'h5678, 4'h3, 32'h0626_0060, 4};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 4'h1, 32'hFFFE_0001, 4};
    vecs[2]  = '{16'h0001, 16'h0001, 4'h2, 32'h0000_0001, 4};
    vecs[3]  = '{16'h0000, 16'hABCD, 4'h4, 32'h0000_0000, 0};
    vecs[4]  = '{16'hABCD, 16'h0000, 4'h5, 32'h0000_0000, 0};
    vecs[5]  = '{16'h00FF, 16'h0100, 4'h6, 32'h0000_FF00, 4};
    vecs[6]  = '{16'h8000, 16'h0002, 4'h7, 32'h0001_0000, 4};
    vecs[7]  = '{16'h00FF, 16'h00FF, 4'h8, 32'h0000_FE01, 4};
    vecs[8]  = '{16'hFF00, 16'hFF00, 4'h9, 32'hFE01_0000, 4};
    vecs[9]  = '{16'h1234, 16'h0001, 4'hA, 32'h0000_1234, 4};
    vecs[10] = '{16'h0100, 16'h0100, 4'hB, 32'h0001_0000, 4};
    vecs[11] = '{16'h0003, 16'h8001, 4'hF, 32'h0001_8003, 4};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    z_in_valid = 1'b0; z_out_ready = 1'b1; z_in_a = '0; z_in_b = '0; z_in_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_txn(i, vecs[i]);

    // Zero operand without the skip still walks all four steps
    begin
      int lat;
      @(negedge clk);
      z_in_a = 16'h0000; z_in_b = 16'hABCD; z_in_tag = 4'h5; z_in_valid = 1'b1;
      @(negedge clk);
      z_in_valid = 1'b0;
      lat = 0;
      while (!z_out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("noskip_latency", lat, 4);
      chk("noskip_res", z_out_res, 0);
      chk("noskip_tag", z_out_tag, 5);
    end

    // Backpressure in DONE with a competing operand offered
    begin
      int lat;
      @(negedge clk);
      in_a = 16'h1234; in_b = 16'h5678; in_tag = 4'h3; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("bp_latency", lat, 4);
      in_a = 16'h1111; in_b = 16'h0002; in_tag = 4'h7; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (k > 0) @(negedge clk);
        chk($sformatf("bp_hold_res%0d", k), out_res, 32'h0626_0060);
        chk($sformatf("bp_hold_tag%0d", k), out_tag, 4'h3);
        chk($sformatf("bp_hold_hs%0d", k), {in_ready, out_valid}, 2'b01);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_after_ready", {in_ready, out_valid, busy}, 3'b100);
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("bp_not_accepted", busy, 0);
    end

    // Asynchronous reset mid-multiply, then accept on the first edge after release
    begin
      int lat;
      @(negedge clk);
      in_a = 16'h00FF; in_b = 16'h0100; in_tag = 4'h9; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_partial_acc", out_res, 32'h0000_FF00);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_hs", {in_ready, out_valid, busy}, 3'b100);
      chk("mid_rst_res", out_res, 0);
      chk("mid_rst_tag", out_tag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      in_a = 16'h0002; in_b = 16'h0003; in_tag = 4'h4; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("post_rst_accept", busy, 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("post_rst_latency", lat, 4);
      chk("post_rst_res", out_res, 32'h0000_0006);
      chk("post_rst_tag", out_tag, 4'h4);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    // Random back-to-back traffic against a reference model
    fork
      begin : drv
        int  sent = 0;
        int  dcyc = 0;
        bit  pend = 1'b0;
        while (sent < NRAND && dcyc < 60000) begin
          @(negedge clk);
          dcyc++;
          if (pend) begin
            in_valid = 1'b0;
            pend = 1'b0;
          end
          if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_a   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            in_b   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            in_tag = 4'($urandom);
            in_valid = 1'b1;
          end
          if (in_valid && in_ready) begin
            q.push_back('{32'(in_a) * 32'(in_b), in_tag});
            sent++;
            pend = 1'b1;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : mon
        int got = 0;
        int cyc = 0;
        exp_t e;
        while (got < NRAND && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rand_extra: result 0x%0h tag %0h with no pending transaction",
                       out_res, out_tag);
            end else begin
              e = q.pop_front();
              chk($sformatf("rand%0d_res", got), out_res, e.res);
              chk($sformatf("rand%0d_tag", got), out_tag, e.tag);
            end
            got++;
          end
        end
        out_ready = 1'b0;
        chk("rand_count", got, NRAND);
      end
    join
    chk("rand_leftover", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
